// File: rtl/motor_pkg.sv
// motor_pkg: shared types and encodings for the motor ramp controller.
// Contents: motor_state_t FSM states, DIR_* direction codes, BRIDGE_* {in1,in2} encodings.
package motor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} motor_state_t;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  localparam logic [1:0] BRIDGE_FWD   = 2'b10;
  localparam logic [1:0] BRIDGE_REV   = 2'b01;
  localparam logic [1:0] BRIDGE_COAST = 2'b00;
  localparam logic [1:0] BRIDGE_BRAKE = 2'b11;
endpackage

// File: rtl/motor_ramp_ctrl_tick_gen.sv
// tick_gen: loadable down-counter giving a one-cycle strobe every N cycles.
// Ports: clk, rst (sync, active-high), restart (reload; suppresses the strobe
// that cycle), tick (one-cycle strobe, first one N cycles after restart).
module tick_gen #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LOAD = CW'(N - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == '0 && !restart;
    cnt_d = (restart || cnt_q == '0) ? LOAD : cnt_q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LOAD;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slew-limited duty/direction command stage with safe reversal.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_duty/cmd_dir
// command handshake (dir 1 = forward); duty to PWM; in1/in2 H-bridge pins;
// at_target when duty equals the accepted target in RUN or IDLE.
// Build option: define MOTOR_ESTOP_EN to add the estop input (brake, hold IDLE).
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int DUTY_WIDTH = 9,
  parameter int DUTY_MAX   = 320,
  parameter int STEP_TICKS = 60000,
  parameter int RAMP_STEP  = 4,
  parameter int DEAD_TICKS = 600
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MOTOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DUTY_WIDTH-1:0] cmd_duty,
  input  logic                  cmd_dir,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  in1,
  output logic                  in2,
  output logic                  at_target
);
  localparam int W = DUTY_WIDTH;
  localparam logic [W-1:0] DMAX = W'(DUTY_MAX);
  localparam logic [W:0] STEP = (W + 1)'(RAMP_STEP);
  motor_state_t state_q, state_d;
  logic [W-1:0] duty_q, duty_d, tgt_q, tgt_d, pend_q, pend_d, ctgt, goal, ramp;
  logic dir_q, dir_d, pdir_q, pdir_d, acc, step_tick, dead_tick, dead_start, stop;
  logic [1:0] br_q, br_d;
  logic [W:0] up, dn;
`ifdef MOTOR_ESTOP_EN
  assign stop = estop;
`else
  assign stop = 1'b0;
`endif
  tick_gen #(.N(STEP_TICKS)) u_step (.clk(clk), .rst(rst), .restart(acc), .tick(step_tick));
  tick_gen #(.N(DEAD_TICKS)) u_dead (.clk(clk), .rst(rst), .restart(dead_start), .tick(dead_tick));
  always_comb begin
    cmd_ready = (state_q == IDLE || state_q == RUN) && !stop;
    acc       = cmd_valid && cmd_ready;
    ctgt      = cmd_duty > DMAX ? DMAX : cmd_duty;
    goal      = state_q == DECEL ? '0 : tgt_q;
    // Widened arithmetic so the step can neither wrap nor overshoot the goal.
    up        = {1'b0, duty_q} + STEP;
    dn        = {1'b0, duty_q} - {1'b0, goal};
    ramp      = duty_q < goal ? (up > {1'b0, goal} ? goal : up[W-1:0])
                              : (dn > STEP ? duty_q - STEP[W-1:0] : goal);
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    pdir_d    = pdir_q;
    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (acc && ctgt != '0) begin
          tgt_d   = ctgt;
          dir_d   = cmd_dir;
          state_d = RUN;
        end
      end
      RUN: begin
        duty_d = step_tick ? ramp : duty_q;
        if (acc && cmd_dir != dir_q && ctgt != '0) begin
          pend_d  = ctgt;
          pdir_d  = cmd_dir;
          state_d = DECEL;
        end else if (acc) tgt_d = ctgt;
        else if (duty_d == '0 && tgt_q == '0) state_d = IDLE;
      end
      DECEL: begin
        duty_d = step_tick ? ramp : duty_q;
        if (duty_d == '0) state_d = DEAD;
      end
      DEAD: begin
        if (dead_tick) begin
          tgt_d   = pend_q;
          dir_d   = pdir_q;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      duty_d  = '0;
      tgt_d   = '0;
      pend_d  = '0;
    end
    // Pins follow the next state so they switch on the transition edge.
    br_d       = stop ? BRIDGE_BRAKE
               : (state_d == RUN || state_d == DECEL) ? (dir_d == DIR_FWD ? BRIDGE_FWD : BRIDGE_REV)
               : BRIDGE_COAST;
    dead_start = state_d == DEAD && state_q != DEAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      dir_q   <= DIR_FWD;
      pend_q  <= '0;
      pdir_q  <= DIR_FWD;
      br_q    <= BRIDGE_COAST;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      br_q    <= br_d;
    end
  end
  assign duty      = duty_q;
  assign in1       = br_q[1];
  assign in2       = br_q[0];
  assign at_target = duty_q == tgt_q && (state_q == RUN || state_q == IDLE);
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed self-checking bench for motor_ramp_ctrl.
module tb_motor_ramp_ctrl;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0;
  logic [8:0] cmd_duty = '0;
  logic cmd_ready, in1, in2, at_target;
  logic [8:0] duty;
`ifdef MOTOR_ESTOP_EN
  logic estop = 1'b0;
`endif
  int nchk = 0, nerr = 0, dmax = 0;
  always #5 clk = ~clk;
  motor_ramp_ctrl #(.DUTY_WIDTH(9), .DUTY_MAX(320), .STEP_TICKS(4), .RAMP_STEP(10), .DEAD_TICKS(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MOTOR_ESTOP_EN
    .estop(estop),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty),
    .cmd_dir(cmd_dir),
    .duty(duty),
    .in1(in1),
    .in2(in2),
    .at_target(at_target)
  );
  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (int'(duty) > dmax) dmax = int'(duty);
    end
  endtask
  task automatic send(input int d, input logic dir);
    cmd_duty  = 9'(d);
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    cyc(1);
    cmd_valid = 1'b0;
  endtask
  function automatic int pins();
    return int'({in1, in2});
  endfunction
  initial begin
    cyc(3);
    chk("rst_duty", int'(duty), 0);
    chk("rst_pins", pins(), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_at_target", int'(at_target), 1);
    rst = 1'b0;
    cyc(2);
    send(35, 1'b1);
    chk("fwd_pins", pins(), 2);
    chk("fwd_at_target0", int'(at_target), 0);
    cyc(4); chk("ramp_10", int'(duty), 10);
    cyc(4); chk("ramp_20", int'(duty), 20);
    cyc(4); chk("ramp_30", int'(duty), 30);
    cyc(4); chk("ramp_35", int'(duty), 35);
    chk("at_target_35", int'(at_target), 1);
    cyc(4); chk("hold_35", int'(duty), 35);
    dmax = 0;
    send(500, 1'b1);
    cyc(112); chk("clamp_315", int'(duty), 315);
    cyc(4); chk("clamp_320", int'(duty), 320);
    cyc(8); chk("clamp_hold", int'(duty), 320);
    chk("clamp_at_target", int'(at_target), 1);
    chk("no_wrap_max", dmax, 320);
    send(30, 1'b1);
    cyc(116); chk("down_30", int'(duty), 30);
    send(20, 1'b0);
    chk("rev_ready0", int'(cmd_ready), 0);
    chk("decel_pins", pins(), 2);
    cyc(4); chk("decel_20", int'(duty), 20);
    cyc(4); chk("decel_10", int'(duty), 10);
    cyc(4); chk("decel_0", int'(duty), 0);
    chk("dead_pins_first", pins(), 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk("dead_pins", pins(), 0);
      chk("dead_ready", int'(cmd_ready), 0);
    end
    cyc(1);
    chk("rev_pins", pins(), 1);
    chk("rev_ready1", int'(cmd_ready), 1);
    chk("rev_duty0", int'(duty), 0);
    cyc(4); chk("rev_10", int'(duty), 10);
    cyc(4); chk("rev_20", int'(duty), 20);
    chk("rev_at_target", int'(at_target), 1);
    send(0, 1'b1);
    chk("zero_pins_keep", pins(), 1);
    cyc(4); chk("zero_10", int'(duty), 10);
    cyc(4); chk("zero_0", int'(duty), 0);
    chk("idle_pins", pins(), 0);
    chk("idle_at_target", int'(at_target), 1);
    chk("idle_ready", int'(cmd_ready), 1);
    send(40, 1'b1);
    chk("idle_acc_pins", pins(), 2);
    cyc(4); chk("idle_acc_10", int'(duty), 10);
    cyc(12); chk("up_40", int'(duty), 40);
    send(30, 1'b0);
    cyc(16);
    chk("dead2_duty", int'(duty), 0);
    chk("dead2_pins", pins(), 0);
    chk("dead2_ready", int'(cmd_ready), 0);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_pins", pins(), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_at_target", int'(at_target), 1);
    rst = 1'b0;
    cyc(20);
    chk("no_pending_pins", pins(), 0);
    chk("no_pending_duty", int'(duty), 0);
`ifdef MOTOR_ESTOP_EN
    send(100, 1'b1);
    cyc(40); chk("estop_pre_100", int'(duty), 100);
    estop = 1'b1;
    cyc(1);
    chk("estop_duty", int'(duty), 0);
    chk("estop_pins", pins(), 3);
    chk("estop_ready", int'(cmd_ready), 0);
    cyc(3); chk("estop_hold_pins", pins(), 3);
    estop = 1'b0;
    cyc(1);
    chk("release_pins", pins(), 0);
    chk("release_ready", int'(cmd_ready), 1);
    chk("release_duty", int'(duty), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
